add_pipe_cla: RTL and testbench
===============================

// Module: add_pipe_cla
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor for the ALU datapath. WIDTH-bit
//  operands are split into NBLK = WIDTH/BLK slices. Each slice is a BLK-bit CLA in its own
//  pipeline stage, with the inter-slice carry registered. Produces sum plus carry, signed
//  overflow and zero flags. A valid/ready handshake with full back-pressure lets it stream
//  one operation per cycle into the execute stage.
// PARAMETERS
//  WIDTH  32  operand/result width; must be a multiple of BLK, >= BLK
//  BLK    8   CLA slice width = bits resolved per pipeline stage
//  TAG_W  5   width of sideband tag carried alongside each operation (e.g. rd index)
// PORTS
//  clk        in   1       single clock, all state updates on rising edge
//  rst        in   1       synchronous, active-high reset
//  in_valid   in   1       operation offered on a/b/op/tag_in
//  in_ready   out  1       stage 0 can accept this cycle
//  a          in   WIDTH   operand A
//  b          in   WIDTH   operand B
//  op         in   1       0 = A+B, 1 = A-B (A + ~B + 1)
//  tag_in     in   TAG_W   sideband tag, returned unchanged with result
//  out_valid  out  1       result/flags/tag_out valid
//  out_ready  in   1       consumer accepts result this cycle
//  sum        out  WIDTH   A+B or A-B, modulo 2^WIDTH
//  cout       out  1       carry out of MSB (sub: 1 = no borrow, i.e. A >= B unsigned)
//  ovf        out  1       signed overflow = carry into MSB XOR carry out of MSB
//  zero       out  1       sum == 0
//  tag_out    out  TAG_W   tag of the operation presented on sum
// BEHAVIOUR
//  - Reset: all stage valid bits cleared; out_valid=0, sum=0, cout=0, ovf=0, zero=0,
//    tag_out=0; in_ready=1 in the first cycle after reset.
//  - Handshake: transfer in on in_valid&in_ready, out on out_valid&out_ready. Inputs are
//    sampled only on transfer; outputs are held stable while out_valid&!out_ready.
//  - Advance: adv = !out_valid | out_ready. When adv=1 every stage shifts one place (bubbles
//    included). When adv=0 the whole pipe freezes. in_ready = adv (combinational from
//    out_ready). Bubbles do not squeeze out; only the output stage gates the pipe.
//  - Stage k (k=0..NBLK-1) computes slice bits [k*BLK +: BLK] with a full BLK-bit CLA
//    (g=a&b, p=a|b, lookahead carries, no ripple inside a slice). Carry-in: stage 0 = op;
//    stage k = registered carry-out of stage k-1. B is inverted when op=1.
//  - Operand skew: unconsumed upper slices of a, b (pre-inverted) and op travel down the
//    pipe. Completed lower sum slices and the running zero-AND also travel down. tag and
//    valid travel with them.
//  - Latency: result visible NBLK cycles after the input transfer with no stall (defaults:
//    4). Throughput is 1 op/cycle with out_ready held high. Each stall cycle adds 1 cycle.
//  - Flags: taken from the last stage. cout = carry out of bit WIDTH-1. ovf = c[WIDTH-2]
//    ^ c[WIDTH-1], where c[WIDTH-2] is the carry into the MSB. zero = AND of the per-slice
//    sum==0 terms.
//  - NBLK=1 degenerates to a single registered CLA with latency 1. Handshake rules are
//    unchanged.
//  - Reset mid-operation: all in-flight ops are discarded (valids cleared). Nothing is
//    emitted for them after reset deasserts.
//  - Simultaneous out-transfer and in-transfer in the same cycle is legal and loses nothing.
//  - Datapath registers other than valid/outputs need no reset. Their values are don't-care
//    while the matching valid=0.
// TESTING
//  1. a=FFFF_FFFF b=1 op=0 tag=3 -> 4 cycles later sum=0 cout=1 ovf=0 zero=1 tag_out=3
//  2. a=7FFF_FFFF b=1 op=0 -> sum=8000_0000 cout=0 ovf=1 zero=0
//  3. a=5 b=7 op=1 -> sum=FFFF_FFFE cout=0 ovf=0. Then a=7 b=7 op=1 -> sum=0 cout=1 zero=1
//  4. Stream 8 random ops back-to-back with out_ready=1 -> 8 consecutive results in order,
//     matching a reference model, tags intact. Repeat with out_ready toggling randomly ->
//     same sequence, no drop or duplication, outputs stable while stalled.
//  5. 3 ops in flight, assert rst 1 cycle -> out_valid=0 and no stale result appears.
//     in_ready=1 next cycle.
//  6. WIDTH=16 BLK=4 and WIDTH=8 BLK=8: exhaustive carry chains (8000+8000, 00FF+0001,
//     FFFF-FFFF) -> correct sum/flags at latency 4 and latency 1 respectively.

Source files
------------

// File: rtl/add_pipe_cla.sv
// Pipelined carry-lookahead adder/subtractor: one BLK-bit CLA slice per stage,
// registered inter-slice carry, valid/ready handshake with whole-pipe stall.
module add_pipe_cla #(
    parameter int WIDTH = 32,
    parameter int BLK   = 8,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             op,
    input  logic [TAG_W-1:0] tag_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [TAG_W-1:0] tag_out
);

    localparam int NBLK = WIDTH / BLK;

    // Returns {carry into slice MSB, slice carry-out, slice sum}; carries are
    // flattened sum-of-products so nothing ripples inside the slice.
    function automatic logic [BLK+1:0] cla(input logic [BLK-1:0] x,
                                            input logic [BLK-1:0] y,
                                            input logic cin);
        logic [BLK-1:0] g, p;
        logic [BLK:0]   c;
        logic           t, prod;
        g    = x & y;
        p    = x | y;
        c[0] = cin;
        for (int unsigned i = 0; i < BLK; i++) begin
            t = cin;
            for (int unsigned m = 0; m <= i; m++) t = t & p[m];
            for (int unsigned j = 0; j <= i; j++) begin
                prod = g[j];
                for (int unsigned m = j + 1; m <= i; m++) prod = prod & p[m];
                t = t | prod;
            end
            c[i+1] = t;
        end
        return {c[BLK-1], c[BLK], x ^ y ^ c[BLK-1:0]};
    endfunction

    logic [NBLK-1:0]  v_r, c_r, z_r;
    logic [WIDTH-1:0] a_r [NBLK];
    logic [WIDTH-1:0] b_r [NBLK];
    logic [WIDTH-1:0] s_r [NBLK];
    logic [TAG_W-1:0] t_r [NBLK];
    logic             ovf_r;

    logic [NBLK-1:0]  src_v, src_c, src_z, nxt_z, sl_cout, sl_cmsb;
    logic [WIDTH-1:0] src_a [NBLK];
    logic [WIDTH-1:0] src_b [NBLK];
    logic [WIDTH-1:0] src_s [NBLK];
    logic [WIDTH-1:0] nxt_s [NBLK];
    logic [TAG_W-1:0] src_t [NBLK];
    logic [BLK-1:0]   sl_sum [NBLK];
    logic             adv;

    assign adv      = !v_r[NBLK-1] | out_ready;
    assign in_ready = adv;

    always_comb begin
        src_v[0] = in_valid;
        src_c[0] = op;
        src_a[0] = a;
        src_b[0] = op ? ~b : b;
        src_s[0] = '0;
        src_z[0] = 1'b1;
        src_t[0] = tag_in;
        for (int unsigned k = 1; k < NBLK; k++) begin
            src_v[k] = v_r[k-1];
            src_c[k] = c_r[k-1];
            src_a[k] = a_r[k-1];
            src_b[k] = b_r[k-1];
            src_s[k] = s_r[k-1];
            src_z[k] = z_r[k-1];
            src_t[k] = t_r[k-1];
        end
        for (int unsigned k = 0; k < NBLK; k++) begin
            {sl_cmsb[k], sl_cout[k], sl_sum[k]} =
                cla(src_a[k][k*BLK +: BLK], src_b[k][k*BLK +: BLK], src_c[k]);
            nxt_s[k]                = src_s[k];
            nxt_s[k][k*BLK +: BLK]  = sl_sum[k];
            nxt_z[k]                = src_z[k] & (sl_sum[k] == '0);
        end
    end

    // Only valids and the output stage are reset; other data is don't-care while invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_r           <= '0;
            c_r[NBLK-1]   <= 1'b0;
            z_r[NBLK-1]   <= 1'b0;
            s_r[NBLK-1]   <= '0;
            t_r[NBLK-1]   <= '0;
            ovf_r         <= 1'b0;
        end else if (adv) begin
            v_r   <= src_v;
            c_r   <= sl_cout;
            z_r   <= nxt_z;
            ovf_r <= sl_cmsb[NBLK-1] ^ sl_cout[NBLK-1];
            for (int unsigned k = 0; k < NBLK; k++) begin
                a_r[k] <= src_a[k];
                b_r[k] <= src_b[k];
                s_r[k] <= nxt_s[k];
                t_r[k] <= src_t[k];
            end
        end
    end

    assign out_valid = v_r[NBLK-1];
    assign sum       = s_r[NBLK-1];
    assign cout      = c_r[NBLK-1];
    assign ovf       = ovf_r;
    assign zero      = z_r[NBLK-1];
    assign tag_out   = t_r[NBLK-1];

endmodule

// File: tb/tb_add_pipe_cla.sv
// Scoreboard bench for add_pipe_cla: directed corner cases, streaming with
// random back-pressure, mid-flight reset, and two narrower configurations.
module tb_add_pipe_cla;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        logic [4:0]  tag;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, op, out_valid, out_ready, cout, ovf, zero;
    logic [31:0] a, b, sum;
    logic [4:0]  tag_in, tag_out;

    logic        s16_in_valid, s16_in_ready, s16_op, s16_out_valid, s16_cout, s16_ovf, s16_zero;
    logic [15:0] s16_a, s16_b, s16_sum;
    logic [4:0]  s16_tag_out;
    logic        s8_in_valid, s8_in_ready, s8_op, s8_out_valid, s8_cout, s8_ovf, s8_zero;
    logic [7:0]  s8_a, s8_b, s8_sum;
    logic [4:0]  s8_tag_out;

    int   n_cmp = 0;
    int   n_err = 0;
    res_t q[$];
    res_t held;
    bit   held_v = 1'b0;

    always #5 clk = ~clk;

    add_pipe_cla dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .op(op), .tag_in(tag_in), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
        .cout(cout), .ovf(ovf), .zero(zero), .tag_out(tag_out)
    );

    add_pipe_cla #(.WIDTH(16), .BLK(4), .TAG_W(5)) dut16 (
        .clk(clk), .rst(rst), .in_valid(s16_in_valid), .in_ready(s16_in_ready), .a(s16_a),
        .b(s16_b), .op(s16_op), .tag_in(5'd9), .out_valid(s16_out_valid), .out_ready(1'b1),
        .sum(s16_sum), .cout(s16_cout), .ovf(s16_ovf), .zero(s16_zero), .tag_out(s16_tag_out)
    );

    add_pipe_cla #(.WIDTH(8), .BLK(8), .TAG_W(5)) dut8 (
        .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready), .a(s8_a),
        .b(s8_b), .op(s8_op), .tag_in(5'd17), .out_valid(s8_out_valid), .out_ready(1'b1),
        .sum(s8_sum), .cout(s8_cout), .ovf(s8_ovf), .zero(s8_zero), .tag_out(s8_tag_out)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference result built from wide integer arithmetic, independent of slicing.
    function automatic res_t model(input int unsigned w, input logic [31:0] x,
                                   input logic [31:0] y, input logic o, input logic [4:0] t);
        longint unsigned mask, xx, yy, full, s;
        logic cin_msb;
        res_t r;
        mask    = (64'd1 << w) - 64'd1;
        xx      = {32'd0, x} & mask;
        yy      = (o ? ~{32'd0, y} : {32'd0, y}) & mask;
        full    = xx + yy + {63'd0, o};
        s       = full & mask;
        r.sum   = s[31:0];
        r.cout  = full[w];
        cin_msb = xx[w-1] ^ yy[w-1] ^ s[w-1];
        r.ovf   = cin_msb ^ r.cout;
        r.zero  = (s == 64'd0);
        r.tag   = t;
        return r;
    endfunction

    // Output monitor: pops the scoreboard on each output transfer, checks hold while stalled.
    always @(negedge clk) begin
        res_t e;
        if (rst) begin
            held_v = 1'b0;
        end else begin
            if (held_v) begin
                check("stall_valid", {63'd0, out_valid}, 64'd1);
                check("stall_hold", {26'd0, sum, cout, ovf, zero, tag_out}, {26'd0, held});
            end
            if (out_valid && out_ready) begin
                held_v = 1'b0;
                if (q.size() == 0) begin
                    check("spurious_out", {63'd0, out_valid}, 64'd0);
                end else begin
                    e = q.pop_front();
                    check("res_sum", {32'd0, sum}, {32'd0, e.sum});
                    check("res_flags", {61'd0, cout, ovf, zero}, {61'd0, e.cout, e.ovf, e.zero});
                    check("res_tag", {59'd0, tag_out}, {59'd0, e.tag});
                end
            end else if (out_valid) begin
                held_v = 1'b1;
                held   = {sum, cout, ovf, zero, tag_out};
            end else begin
                held_v = 1'b0;
            end
        end
    end

    task automatic run32(input logic [31:0] x, input logic [31:0] y, input logic o,
                         input logic [4:0] t, input logic [31:0] esum,
                         input logic ec, input logic eo, input logic ez);
        int lat;
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 1'b1; a = x; b = y; op = o; tag_in = t;
        q.push_back(model(32, x, y, o, t));
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("lat32", lat, 4);
        check("dir_sum", {32'd0, sum}, {32'd0, esum});
        check("dir_flags", {61'd0, cout, ovf, zero}, {61'd0, ec, eo, ez});
        check("dir_tag", {59'd0, tag_out}, {59'd0, t});
    endtask

    task automatic run_small(input int w, input logic [15:0] x, input logic [15:0] y,
                             input logic o, input logic [15:0] esum,
                             input logic ec, input logic eo, input logic ez);
        int lat;
        @(posedge clk); #1;
        if (w == 16) begin
            s16_in_valid = 1'b1; s16_a = x; s16_b = y; s16_op = o;
        end else begin
            s8_in_valid = 1'b1; s8_a = x[7:0]; s8_b = y[7:0]; s8_op = o;
        end
        @(posedge clk); #1;
        s16_in_valid = 1'b0;
        s8_in_valid  = 1'b0;
        lat = 1;
        while (!(w == 16 ? s16_out_valid : s8_out_valid) && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        if (w == 16) begin
            check("lat16", lat, 4);
            check("s16_sum", {48'd0, s16_sum}, {48'd0, esum});
            check("s16_flags", {61'd0, s16_cout, s16_ovf, s16_zero}, {61'd0, ec, eo, ez});
            check("s16_tag", {59'd0, s16_tag_out}, 64'd9);
        end else begin
            check("lat8", lat, 1);
            check("s8_sum", {56'd0, s8_sum}, {48'd0, esum});
            check("s8_flags", {61'd0, s8_cout, s8_ovf, s8_zero}, {61'd0, ec, eo, ez});
            check("s8_tag", {59'd0, s8_tag_out}, 64'd17);
        end
    endtask

    task automatic stream(input int n, input bit rnd);
        logic [31:0] va [16];
        logic [31:0] vb [16];
        logic        vo [16];
        int idx = 0;
        int cyc = 0;
        for (int i = 0; i < n; i++) begin
            va[i] = $urandom;
            vb[i] = (i == 2) ? va[i] : $urandom;
            vo[i] = 1'($urandom_range(0, 1));
        end
        while ((idx < n || q.size() != 0) && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (idx < n) begin
                in_valid = 1'b1; a = va[idx]; b = vb[idx]; op = vo[idx]; tag_in = 5'(idx + 20);
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (in_valid && in_ready) begin
                q.push_back(model(32, va[idx], vb[idx], vo[idx], 5'(idx + 20)));
                idx++;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_sent", idx, n);
        check("stream_drained", q.size(), 0);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = 1'b0; tag_in = '0;
        s16_in_valid = 1'b0; s16_a = '0; s16_b = '0; s16_op = 1'b0;
        s8_in_valid = 1'b0; s8_a = '0; s8_b = '0; s8_op = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        check("rst_outputs", {26'd0, sum, cout, ovf, zero, tag_out}, 64'd0);

        run32(32'hFFFF_FFFF, 32'h1, 1'b0, 5'd3, 32'h0, 1'b1, 1'b0, 1'b1);
        run32(32'h7FFF_FFFF, 32'h1, 1'b0, 5'd4, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        run32(32'h5, 32'h7, 1'b1, 5'd5, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        run32(32'h7, 32'h7, 1'b1, 5'd6, 32'h0, 1'b1, 1'b0, 1'b1);
        run32(32'h8000_0000, 32'h1, 1'b1, 5'd7, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);

        stream(8, 1'b0);
        stream(12, 1'b1);

        // Three ops in flight, then a one-cycle reset must discard all of them.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            out_ready = 1'b1; in_valid = 1'b1;
            a = 32'(i + 1); b = 32'h10; op = 1'b0; tag_in = 5'(i + 1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        check("rst2_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst2_in_ready", {63'd0, in_ready}, 64'd1);
        repeat (8) @(posedge clk);
        #1;
        check("rst2_idle", {63'd0, out_valid}, 64'd0);

        run_small(16, 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_small(16, 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        run_small(16, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_small(8, 16'h0080, 16'h0080, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        run_small(8, 16'h00FF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_small(8, 16'h00FF, 16'h00FF, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_small(8, 16'h0003, 16'h0005, 1'b1, 16'h00FE, 1'b0, 1'b0, 1'b0);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
